// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the pipelined bitwise logic unit.
// Optional feature macro used by the top: LOGIC_UNIT_PARITY_EN.
package logic_unit_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_XNOR  = 3'b100,
        OP_ANDN  = 3'b101,
        OP_PASSA = 3'b110,
        OP_ACCX  = 3'b111
    } logic_op_e;

    function automatic logic is_accx(input logic_op_e op);
        return (op == OP_ACCX);
    endfunction

endpackage

// File: rtl/logic_unit_core.sv
// Combinational evaluator for the eight bitwise operations; ACCX folds the
// running accumulator into a ^ b.
module logic_unit_core
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic_op_e          op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]   result,
    output logic               zero
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:   result = a & b;
            OP_OR:    result = a | b;
            OP_XOR:   result = a ^ b;
            OP_NOR:   result = ~(a | b);
            OP_XNOR:  result = ~(a ^ b);
            OP_ANDN:  result = a & ~b;
            OP_PASSA: result = a;
            OP_ACCX:  result = acc ^ a ^ b;
            default:  result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready bitwise logic unit with XOR-accumulate groups.
// Define LOGIC_UNIT_PARITY_EN to add the registered out_parity output.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
`ifdef LOGIC_UNIT_PARITY_EN
    output logic               out_parity,
`endif
    output logic               out_zero
);

    logic               s1_valid;
    logic_op_e          s1_op;
    logic [WIDTH-1:0]   s1_a;
    logic [WIDTH-1:0]   s1_b;
    logic               s1_last;

    logic               s2_valid;
    logic [WIDTH-1:0]   s2_result;
    logic               s2_zero;
    logic [WIDTH-1:0]   acc;

    logic [WIDTH-1:0]   core_result;
    logic               core_zero;
    logic               s2_free;
    logic               s1_adv;
    logic               s1_absorb;
    logic               accept;

    // An absorbed ACCX beat still waits for a free S2 so group ordering stays simple.
    assign s2_free   = !s2_valid || out_ready;
    assign s1_adv    = s1_valid && s2_free;
    assign in_ready  = !s1_valid || s2_free;
    assign accept    = in_valid && in_ready;
    assign s1_absorb = is_accx(s1_op) && !s1_last;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .acc    (acc),
        .result (core_result),
        .zero   (core_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_AND;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_last  <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_op    <= logic_op_e'(in_op);
            s1_a     <= in_a;
            s1_b     <= in_b;
            s1_last  <= in_last;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            s2_result <= '0;
            s2_zero   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= !s1_absorb;
            if (!s1_absorb) begin
                s2_result <= core_result;
                s2_zero   <= core_zero;
            end
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    // A closing ACCX beat hands acc ^ a ^ b to S2 and restarts the group at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (s1_adv && is_accx(s1_op)) begin
            acc <= s1_last ? '0 : core_result;
        end
    end

`ifdef LOGIC_UNIT_PARITY_EN
    logic s2_parity;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_parity <= 1'b0;
        end else if (s1_adv && !s1_absorb) begin
            s2_parity <= ^core_result;
        end
    end

    assign out_parity = s2_parity;
`endif

    assign out_valid  = s2_valid;
    assign out_result = s2_result;
    assign out_zero   = s2_zero;

endmodule
